vga_text_overlay: RTL
=====================

// Module: vga_text_overlay
// PURPOSE
//  Parametrised text-line renderer between the vga timing core (x, y, valid, sync, newframe) and the RGB pins.
//  Holds an N_CHARS writable character buffer and drives an external chars font ROM (code, rownum -> 8 pixels).
//  Draws one line of 8x8 glyphs, scaled by 2^SCALE_LOG2, at a frame-latched position; sync is delayed to match.
// PARAMETERS
//  N_CHARS     8      characters per line (1..64)
//  CODE_W      4      character code width
//  SCALE_LOG2  0      glyph scale 2^SCALE_LOG2 (0..2)
//  X0_RST      10'd8  window x origin after reset
//  Y0_RST      10'd300 window y origin after reset
//  BLANK_CODE  4'd15  code written by reset; overlay treats it as transparent
//  FG_RGB      3'b111 foreground {R,G,B};  BG_RGB 3'b000 background
// PORTS
//  clk        in  1        system clock (single clock domain)
//  rst        in  1        reset, asynchronous, active-high
//  pix_en     in  1        one-cycle pixel strobe (clk25 tick); pipeline advances only when high
//  x, y       in  10 each  current pixel coordinates from vga
//  valid      in  1        active-video flag
//  hsync_in   in  1        raw hsync;  vsync_in in 1 raw vsync
//  newframe   in  1        frame-start pulse (qualified by pix_en)
//  ovl_en     in  1        0 forces background on all active pixels
//  pos_x      in  10       requested window x origin, latched at frame start
//  pos_y      in  10       requested window y origin, latched at frame start
//  wr_en      in  1        char buffer write strobe (any clk cycle)
//  wr_addr    in  6        char slot; addresses >= N_CHARS ignored
//  wr_data    in  CODE_W   char code
//  font_char  out CODE_W   code to font ROM (combinational from stage-2 regs)
//  font_row   out 3        glyph row to font ROM
//  font_pix   in  8        font row bits, MSB = leftmost pixel, combinational return
//  rgb        out 3        {R,G,B} pixel
//  hsync_out  out 1        hsync delayed to align with rgb;  vsync_out out 1 likewise
// BEHAVIOUR
//  Reset: rgb=BG_RGB, hsync_out=hsync_in reset level 0, vsync_out=0, all buffer slots=BLANK_CODE,
//   window origin=(X0_RST,Y0_RST), pipeline valid bits 0.
//  Origin: pos_x/pos_y sampled on clk where pix_en&newframe; unchanged mid-frame (no tearing).
//  Window: dx=x-org_x, dy=y-org_y (10-bit, unsigned); in_win = valid & dx<N_CHARS*8<<S & dy<8<<S.
//   col=dx>>(3+S), bit=(dx>>S)[2:0], row=(dy>>S)[2:0]. Window clipped at x>=640/y>=480 by valid.
//  Pipeline (each stage loads only when pix_en=1; holds otherwise):
//   S1: register in_win, col, bit, row, valid, hsync_in, vsync_in.
//   S2: register code=buf[col] (old data if written same cycle), bit, row, flags.
//   S3: rgb = !valid2 ? 3'b000 : (ovl_en & in_win2 & code!=BLANK_CODE & font_pix[7-bit]) ? FG_RGB : BG_RGB.
//  Latency: rgb, hsync_out, vsync_out exactly 3 pix_en strobes after x/y/sync inputs.
//  Buffer write: takes effect next clk; visible on any pixel whose S2 load follows the write.
//  Write with wr_addr>=N_CHARS: no state change. wr_en and pix_en together: both proceed.
//  Reset mid-frame: outputs return to reset values immediately; first valid rgb 3 strobes after release.
// CONFIGURATION
//  TEXT_OVERLAY_BLINK_EN defined: each slot stores extra blink bit (wr_data width CODE_W+1, MSB=blink);
//   6-bit frame counter increments per newframe strobe, wraps 63->0; blinking glyphs render BG while
//   counter[5]=1 (32 frames on, 32 off). Counter and blink bits reset to 0.
//  Undefined: no blink bit, no counter; wr_data width CODE_W; glyphs always shown.
// TESTING
//  1. Reset, no writes, full frame -> rgb==BG_RGB every active pixel; buffer reads BLANK_CODE.
//  2. Write codes 10,12,14 to slots 0..2, origin (8,300), S=0 -> FG exactly where font bits set, x 8..31, y 300..307; rgb lags x by 3 strobes.
//  3. SCALE_LOG2=1: pixel (8,300) and (9,301) identical; window ends at x=8+N_CHARS*16-1.
//  4. Change pos_x to 100 mid-frame -> current frame unchanged; next frame glyph 0 starts at x=100.
//  5. wr_en with wr_addr=N_CHARS -> no visible change; same-cycle write/read of slot 1 -> old code shown that pixel.
//  6. BLINK_EN: slot 0 blink=1 -> glyph visible frames 0..31, blank 32..63, visible frame 64; rst mid-frame -> rgb=BG, counter 0.

Source files
------------

// File: rtl/vga_text_overlay_if.sv
// Character buffer write port shared by the overlay and whoever fills it.
// DATA_W is CODE_W, or CODE_W+1 when TEXT_OVERLAY_BLINK_EN adds the blink bit.
interface vga_text_overlay_if #(
  parameter int unsigned DATA_W = 4
);
  logic              wr_en;
  logic [5:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_text_overlay.sv
// One-line 8x8 text renderer between the VGA timing core and the RGB pins.
// Optional per-slot blinking is built when TEXT_OVERLAY_BLINK_EN is defined.
module vga_text_overlay #(
  parameter int unsigned       N_CHARS    = 8,
  parameter int unsigned       CODE_W     = 4,
  parameter int unsigned       SCALE_LOG2 = 0,
  parameter logic [9:0]        X0_RST     = 10'd8,
  parameter logic [9:0]        Y0_RST     = 10'd300,
  parameter logic [CODE_W-1:0] BLANK_CODE = CODE_W'(15),
  parameter logic [2:0]        FG_RGB     = 3'b111,
  parameter logic [2:0]        BG_RGB     = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              valid,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              newframe,
  input  logic              ovl_en,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  vga_text_overlay_if.slave wr,
  output logic [CODE_W-1:0] font_char,
  output logic [2:0]        font_row,
  input  logic [7:0]        font_pix,
  output logic [2:0]        rgb,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam int unsigned COL_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam int unsigned BUF_D = 1 << COL_W;
  localparam int unsigned WIN_W = (N_CHARS * 8) << SCALE_LOG2;
  localparam int unsigned WIN_H = 8 << SCALE_LOG2;
`ifdef TEXT_OVERLAY_BLINK_EN
  localparam int unsigned ENT_W = CODE_W + 1;
`else
  localparam int unsigned ENT_W = CODE_W;
`endif
  localparam logic [ENT_W-1:0] BLANK_ENT = ENT_W'(BLANK_CODE);

  logic [9:0]        org_x;
  logic [9:0]        org_y;
  logic [ENT_W-1:0]  char_mem [BUF_D];

  logic [9:0]        dx_c;
  logic [9:0]        dy_c;
  logic              in_win_c;
  logic [COL_W-1:0]  col_c;
  logic [2:0]        bit_c;
  logic [2:0]        row_c;
  logic [ENT_W-1:0]  rd_ent_c;
  logic              glyph_on_c;

  logic              s1_in_win;
  logic [COL_W-1:0]  s1_col;
  logic [2:0]        s1_bit;
  logic [2:0]        s1_row;
  logic              s1_valid;
  logic              s1_hs;
  logic              s1_vs;

  logic              s2_in_win;
  logic [CODE_W-1:0] s2_code;
  logic [2:0]        s2_bit;
  logic [2:0]        s2_row;
  logic              s2_valid;
  logic              s2_hs;
  logic              s2_vs;

`ifdef TEXT_OVERLAY_BLINK_EN
  logic              s2_blink;
  logic [5:0]        frame_cnt;
`endif

  // Window origin only moves at frame start so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      org_x <= X0_RST;
      org_y <= Y0_RST;
    end else if (pix_en && newframe) begin
      org_x <= pos_x;
      org_y <= pos_y;
    end
  end

  // Character buffer; out-of-range slots are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_D); i++) begin
        char_mem[i] <= BLANK_ENT;
      end
    end else if (wr.wr_en && ({1'b0, wr.wr_addr} < 7'(N_CHARS))) begin
      char_mem[COL_W'(wr.wr_addr)] <= wr.wr_data;
    end
  end

`ifdef TEXT_OVERLAY_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 6'd0;
    end else if (pix_en && newframe) begin
      frame_cnt <= frame_cnt + 6'd1;
    end
  end
`endif

  // Window hit test and glyph addressing; wraparound keeps dx/dy unsigned.
  always_comb begin
    dx_c     = x - org_x;
    dy_c     = y - org_y;
    in_win_c = valid && (12'(dx_c) < 12'(WIN_W)) && (12'(dy_c) < 12'(WIN_H));
    col_c    = COL_W'(dx_c >> (3 + SCALE_LOG2));
    bit_c    = 3'(dx_c >> SCALE_LOG2);
    row_c    = 3'(dy_c >> SCALE_LOG2);
    rd_ent_c = char_mem[s1_col];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_in_win <= 1'b0;
      s1_col    <= '0;
      s1_bit    <= 3'd0;
      s1_row    <= 3'd0;
      s1_valid  <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else if (pix_en) begin
      s1_in_win <= in_win_c;
      s1_col    <= col_c;
      s1_bit    <= bit_c;
      s1_row    <= row_c;
      s1_valid  <= valid;
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
    end
  end

  // Buffer read; a write in the same cycle lands after this load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_in_win <= 1'b0;
      s2_code   <= BLANK_CODE;
      s2_bit    <= 3'd0;
      s2_row    <= 3'd0;
      s2_valid  <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
`ifdef TEXT_OVERLAY_BLINK_EN
      s2_blink  <= 1'b0;
`endif
    end else if (pix_en) begin
      s2_in_win <= s1_in_win;
      s2_code   <= rd_ent_c[CODE_W-1:0];
      s2_bit    <= s1_bit;
      s2_row    <= s1_row;
      s2_valid  <= s1_valid;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
`ifdef TEXT_OVERLAY_BLINK_EN
      s2_blink  <= rd_ent_c[ENT_W-1];
`endif
    end
  end

  assign font_char = s2_code;
  assign font_row  = s2_row;

  always_comb begin
    glyph_on_c = ovl_en && s2_in_win && (s2_code != BLANK_CODE)
                 && font_pix[3'(3'd7 - s2_bit)];
`ifdef TEXT_OVERLAY_BLINK_EN
    if (s2_blink && frame_cnt[5]) begin
      glyph_on_c = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= BG_RGB;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (pix_en) begin
      rgb       <= !s2_valid ? 3'b000 : (glyph_on_c ? FG_RGB : BG_RGB);
      hsync_out <= s2_hs;
      vsync_out <= s2_vs;
    end
  end

endmodule
